// File: rtl/pipe_ctrl_fsm.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates memory waits, redirects,
// hazards and the HALT drain, and counts cycles in which the PC is held.
module pipe_ctrl_fsm #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hz_stall,
  input  logic             br_stall,
  input  logic             redirect,
  input  logic             imem_stall,
  input  logic             imem_done,
  input  logic             dmem_stall,
  input  logic             dmem_done,
  input  logic             halt_id,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [2:0] {S_RUN, S_DWAIT, S_IWAIT, S_DRAIN, S_HALTED} state_t;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

  state_t        state, state_nx;
  logic          redir_pend, pend_nx;
  logic          ret_drain, ret_nx;
  logic          fetch_held, held_nx;
  logic [DW-1:0] drain_cnt, cnt_nx;

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_we    = 1'b1;
    memwb_we    = 1'b1;
    state_nx    = state;
    pend_nx     = redir_pend;
    ret_nx      = ret_drain;
    held_nx     = fetch_held;
    cnt_nx      = drain_cnt;
    case (state)
      S_RUN: begin
        if (dmem_stall) begin
          {pc_we, ifid_we, exmem_we, memwb_we} = 4'b0000;
          pend_nx  = redirect;
          ret_nx   = 1'b0;
          state_nx = S_DWAIT;
        end else if (redirect) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (imem_stall) begin
          pc_we      = 1'b0;
          ifid_flush = 1'b1;
          state_nx   = S_IWAIT;
        end else if (halt_id) begin
          pc_we    = 1'b0;
          ifid_we  = 1'b0;
          cnt_nx   = DRAIN_INIT;
          state_nx = S_DRAIN;
        end else if (hz_stall || br_stall) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_bubble = 1'b1;
        end
      end
      S_DWAIT: begin
        if (!dmem_done) begin
          {pc_we, ifid_we, exmem_we, memwb_we} = 4'b0000;
          pend_nx = redir_pend | redirect;
        end else if (redir_pend || redirect) begin
          // A redirect owed across the freeze also cancels a pending drain.
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          pend_nx     = 1'b0;
          state_nx    = S_RUN;
        end else if (ret_drain) begin
          pc_we       = 1'b0;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (drain_cnt == '0) state_nx = S_HALTED;
          else begin
            cnt_nx   = drain_cnt - 1'b1;
            state_nx = S_DRAIN;
          end
        end else begin
          state_nx = S_RUN;
        end
      end
      S_IWAIT: begin
        if (dmem_stall) begin
          // Fetch completion seen under a data freeze is held until the freeze lifts.
          {pc_we, ifid_we, exmem_we, memwb_we} = 4'b0000;
          pend_nx = redir_pend | redirect;
          held_nx = fetch_held | imem_done;
        end else if (imem_done || fetch_held) begin
          ifid_flush  = redir_pend | redirect;
          idex_bubble = redir_pend | redirect;
          pend_nx     = 1'b0;
          held_nx     = 1'b0;
          state_nx    = S_RUN;
        end else begin
          pc_we      = 1'b0;
          ifid_flush = 1'b1;
          pend_nx    = redir_pend | redirect;
        end
      end
      S_DRAIN: begin
        if (dmem_stall) begin
          {pc_we, ifid_we, exmem_we, memwb_we} = 4'b0000;
          pend_nx  = redirect;
          ret_nx   = 1'b1;
          state_nx = S_DWAIT;
        end else if (redirect) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          state_nx    = S_RUN;
        end else begin
          pc_we       = 1'b0;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (drain_cnt == '0) state_nx = S_HALTED;
          else cnt_nx = drain_cnt - 1'b1;
        end
      end
      S_HALTED: begin
        {pc_we, ifid_we, exmem_we, memwb_we} = 4'b0000;
      end
      default: begin
        state_nx = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_RUN;
      redir_pend <= 1'b0;
      ret_drain  <= 1'b0;
      fetch_held <= 1'b0;
      drain_cnt  <= '0;
      halted     <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      state      <= state_nx;
      redir_pend <= pend_nx;
      ret_drain  <= ret_nx;
      fetch_held <= held_nx;
      drain_cnt  <= cnt_nx;
      halted     <= (state_nx == S_HALTED);
      if (!pc_we && state != S_HALTED && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_fsm.sv
// Bench for pipe_ctrl_fsm: directed scenarios then random traffic, all checked against
// a pipeline-level model of what each cycle should do; a CNT_W=4 copy checks saturation.
module tb_pipe_ctrl_fsm;

  localparam int DRAIN_CYCLES = 3;
  localparam logic [5:0] ADVANCE = 6'b110011;
  localparam logic [5:0] FREEZE  = 6'b000000;
  localparam logic [5:0] FLUSH   = 6'b111111;
  localparam logic [5:0] IMISS   = 6'b011011;
  localparam logic [5:0] HALTIS  = 6'b000011;
  localparam logic [5:0] HAZARD  = 6'b000111;
  localparam logic [5:0] DRAIN   = 6'b011111;

  logic clk = 1'b0;
  logic rst_n = 1'b0, hz_stall = 1'b0, br_stall = 1'b0, redirect = 1'b0;
  logic imem_stall = 1'b0, imem_done = 1'b0, dmem_stall = 1'b0, dmem_done = 1'b0, halt_id = 1'b0;
  logic pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we, halted;
  logic [15:0] stall_cnt;
  logic pc_we4, ifid_we4, ifid_flush4, idex_bubble4, exmem_we4, memwb_we4, halted4;
  logic [3:0] stall_cnt4;

  int checks = 0;
  int failures = 0;

  // Model: what the pipeline is waiting for, what it owes, and where HALT is.
  bit m_valid, m_dwait, m_fwait, m_fready, m_owe, m_halted;
  int m_halt_left = -1;
  int m_stalls;

  pipe_ctrl_fsm #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .hz_stall(hz_stall), .br_stall(br_stall), .redirect(redirect),
    .imem_stall(imem_stall), .imem_done(imem_done), .dmem_stall(dmem_stall), .dmem_done(dmem_done),
    .halt_id(halt_id), .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .exmem_we(exmem_we), .memwb_we(memwb_we), .halted(halted),
    .stall_cnt(stall_cnt));

  pipe_ctrl_fsm #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .hz_stall(hz_stall), .br_stall(br_stall), .redirect(redirect),
    .imem_stall(imem_stall), .imem_done(imem_done), .dmem_stall(dmem_stall), .dmem_done(dmem_done),
    .halt_id(halt_id), .pc_we(pc_we4), .ifid_we(ifid_we4), .ifid_flush(ifid_flush4),
    .idex_bubble(idex_bubble4), .exmem_we(exmem_we4), .memwb_we(memwb_we4), .halted(halted4),
    .stall_cnt(stall_cnt4));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drain_one(output logic [5:0] act);
    act = DRAIN;
    if (m_halt_left == 0) begin
      m_halted = 1'b1;
      m_halt_left = -1;
    end else begin
      m_halt_left--;
    end
  endtask

  task automatic model_step(input bit hz, br, rd, ims, imd, dms, dmd, hl, output logic [5:0] act);
    bit was_halted = m_halted;
    act = ADVANCE;
    if (m_halted) begin
      act = FREEZE;
    end else if (m_dwait) begin
      if (!dmd) begin
        act = FREEZE;
        m_owe |= rd;
      end else begin
        m_dwait = 1'b0;
        if (m_owe || rd) begin
          act = FLUSH;
          m_owe = 1'b0;
          m_halt_left = -1;
        end else if (m_halt_left >= 0) begin
          drain_one(act);
        end
      end
    end else if (m_fwait) begin
      if (dms) begin
        act = FREEZE;
        m_owe |= rd;
        m_fready |= imd;
      end else if (imd || m_fready) begin
        act = (m_owe || rd) ? FLUSH : ADVANCE;
        m_owe = 1'b0;
        m_fready = 1'b0;
        m_fwait = 1'b0;
      end else begin
        act = IMISS;
        m_owe |= rd;
      end
    end else if (m_halt_left >= 0) begin
      if (dms) begin
        act = FREEZE;
        m_dwait = 1'b1;
        m_owe = rd;
      end else if (rd) begin
        act = FLUSH;
        m_halt_left = -1;
      end else begin
        drain_one(act);
      end
    end else begin
      if (dms) begin
        act = FREEZE;
        m_dwait = 1'b1;
        m_owe = rd;
      end else if (rd) act = FLUSH;
      else if (ims) begin
        act = IMISS;
        m_fwait = 1'b1;
      end else if (hl) begin
        act = HALTIS;
        m_halt_left = DRAIN_CYCLES - 1;
      end else if (hz || br) act = HAZARD;
    end
    if (!was_halted && !act[5] && m_stalls < 65535) m_stalls++;
  endtask

  task automatic step(input bit r, hz, br, rd, ims, imd, dms, dmd, hl);
    logic [5:0] act;
    rst_n = r; hz_stall = hz; br_stall = br; redirect = rd; imem_stall = ims;
    imem_done = imd; dmem_stall = dms; dmem_done = dmd; halt_id = hl;
    @(negedge clk);
    if (m_valid) begin
      check("halted", {31'd0, halted}, {31'd0, m_halted});
      check("stall_cnt", {16'd0, stall_cnt}, m_stalls);
      check("stall_cnt4", {28'd0, stall_cnt4}, (m_stalls > 15) ? 15 : m_stalls);
      if (r) begin
        model_step(hz, br, rd, ims, imd, dms, dmd, hl, act);
        check("ctrl", {26'd0, pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we}, {26'd0, act});
        check("ctrl4", {26'd0, pc_we4, ifid_we4, ifid_flush4, idex_bubble4, exmem_we4, memwb_we4},
              {26'd0, act});
      end
    end
    if (!r) begin
      m_valid = 1'b1; m_dwait = 1'b0; m_fwait = 1'b0; m_fready = 1'b0;
      m_owe = 1'b0; m_halted = 1'b0; m_halt_left = -1; m_stalls = 0;
    end
    @(posedge clk);
    #1;
  endtask

  //           r hz br rd ims imd dms dmd hl
  initial begin
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("hz3_cnt", {16'd0, stall_cnt}, 32'd3);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_cnt", {16'd0, stall_cnt}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    // Data stall with redirect on its first cycle, then a plain one.
    step(1, 0, 0, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    // Fetch miss with redirect in the middle.
    step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    // Fetch completion under a data freeze.
    step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Clean halt, then junk while halted.
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < DRAIN_CYCLES; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("halted_set", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 1, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Wrong-path halt cancelled by a redirect on the second drain cycle.
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("halt_cancel", {31'd0, halted}, 32'd0);
    // Halt drain interrupted by a data stall.
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Counter saturation in the narrow copy.
    for (int i = 0; i < 21; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("sat4", {28'd0, stall_cnt4}, 32'd15);
    check("cnt16_21", {16'd0, stall_cnt}, 32'd21);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 39) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
